// File: rtl/conv_sequencer.sv
`default_nettype none
// ============================================================================
// conv_sequencer: load / issue / drain / output scheduler for the 1-D conv datapath
// Rev 1.0
// ============================================================================
module conv_sequencer #(
  parameter int LENX  = 8,
  parameter int LENF  = 4,
  parameter int ADDRX = 3,
  parameter int ADDRF = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid_x,
  output logic             s_ready_x,
  output logic             x_wr_en,
  output logic [ADDRX-1:0] x_addr,
  output logic [ADDRF-1:0] f_addr,
  output logic             acc_en,
  output logic             acc_first,
  output logic             m_valid_y,
  input  logic             m_ready_y,
  output logic             last_y,
  output logic             busy
);

  localparam logic [ADDRX-1:0] c_wcnt_last = ADDRX'(LENX - 1);
  localparam logic [ADDRX-1:0] c_j_last    = ADDRX'(LENX - LENF);
  localparam logic [ADDRF-1:0] c_k_last    = ADDRF'(LENF - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [ADDRX-1:0] wcnt_q, wcnt_d;
  logic [ADDRX-1:0] j_q, j_d;
  logic [ADDRF-1:0] k_q, k_d;
  logic [ADDRX-1:0] xa_q, xa_d;
  logic [ADDRF-1:0] fa_q, fa_d;
  logic             acc_en_q, acc_en_d;
  logic             acc_first_q, acc_first_d;
  logic [ADDRX-1:0] w_rd_addr;

  assign w_rd_addr = j_q + ADDRX'(k_q);
  assign acc_en    = acc_en_q;
  assign acc_first = acc_first_q;
  assign busy      = (state_q != LOAD);

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    j_d         = j_q;
    k_d         = k_q;
    xa_d        = xa_q;
    fa_d        = fa_q;
    acc_en_d    = 1'b0;
    acc_first_d = 1'b0;
    s_ready_x   = 1'b0;
    x_wr_en     = 1'b0;
    x_addr      = xa_q;
    f_addr      = fa_q;
    m_valid_y   = 1'b0;
    last_y      = 1'b0;
    case (state_q)
      LOAD: begin
        s_ready_x = 1'b1;
        x_addr    = wcnt_q;
        x_wr_en   = s_valid_x;
        if (s_valid_x) begin
          if (wcnt_q == c_wcnt_last) begin
            wcnt_d  = '0;
            j_d     = '0;
            k_d     = '0;
            state_d = ISSUE;
          end else begin
            wcnt_d = wcnt_q + ADDRX'(1);
          end
        end
      end
      ISSUE: begin
        // Read addresses go out now; the matching accumulate strobe trails by one cycle
        x_addr      = w_rd_addr;
        f_addr      = k_q;
        xa_d        = w_rd_addr;
        fa_d        = k_q;
        acc_en_d    = 1'b1;
        acc_first_d = (k_q == '0);
        if (k_q == c_k_last) begin
          k_d     = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + ADDRF'(1);
        end
      end
      DRAIN: begin
        state_d = OUTPUT;
      end
      OUTPUT: begin
        m_valid_y = 1'b1;
        last_y    = (j_q == c_j_last);
        if (m_ready_y) begin
          if (j_q == c_j_last) begin
            state_d = LOAD;
          end else begin
            j_d     = j_q + ADDRX'(1);
            state_d = ISSUE;
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      wcnt_q      <= '0;
      j_q         <= '0;
      k_q         <= '0;
      xa_q        <= '0;
      fa_q        <= '0;
      acc_en_q    <= 1'b0;
      acc_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      j_q         <= j_d;
      k_q         <= k_d;
      xa_q        <= xa_d;
      fa_q        <= fa_d;
      acc_en_q    <= acc_en_d;
      acc_first_q <= acc_first_d;
    end
  end

endmodule
`default_nettype wire
